// File: rtl/ram_arb_pkg.sv
// Shared constants for the frame-buffer RAM port arbiter and its helpers.
package ram_arb_pkg;

    localparam int unsigned N_REQ    = 3;       // requesters sharing the port
    localparam int unsigned AW       = 17;      // RAM address width
    localparam int unsigned DW       = 24;      // RAM data width (RGB888)
    localparam int unsigned DEPTH    = 120000;  // 400 x 300 frame
    localparam int unsigned LOCK_MAX = 400;     // one image row

    // Requester indices
    localparam int unsigned REQ_PIXEL  = 0;     // pixel capture
    localparam int unsigned REQ_FILTER = 1;     // filter read
    localparam int unsigned REQ_OUTPUT = 2;     // output read

    // Width of an index into n items (never less than one bit)
    function automatic int unsigned idxWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold the value maxVal
    function automatic int unsigned cntWidth(input int unsigned maxVal);
        return (maxVal > 0) ? $clog2(maxVal + 1) : 1;
    endfunction

endpackage

// File: rtl/ram_port_arb_rr_pick.sv
// Cyclic priority selector: one-hot grant to the first requester after lastGnt.
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] lastGnt,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [IW-1:0] idx;

    // Walk lastGnt+1 .. lastGnt+N (mod N); lastGnt itself is checked last
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = IW'((32'(lastGnt) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arb.sv
// Round-robin arbiter with row locking for the single-port frame RAM (ram2).
module ram_port_arb #(
    parameter int unsigned N_REQ    = ram_arb_pkg::N_REQ,
    parameter int unsigned AW       = ram_arb_pkg::AW,
    parameter int unsigned DW       = ram_arb_pkg::DW,
    parameter int unsigned DEPTH    = ram_arb_pkg::DEPTH,
    parameter int unsigned LOCK_MAX = ram_arb_pkg::LOCK_MAX
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    input  logic [N_REQ-1:0]    iREQ,
    input  logic [N_REQ-1:0]    iLOCK,
    input  logic [N_REQ-1:0]    iWE,
    input  logic [N_REQ*AW-1:0] iADDR,
    input  logic [N_REQ*DW-1:0] iWDATA,
    output logic [N_REQ-1:0]    oGNT,
    output logic [N_REQ-1:0]    oRVAL,
    output logic [DW-1:0]       oRDATA,
    output logic [AW-1:0]       oRAM_ADDR,
    output logic [DW-1:0]       oRAM_DATA,
    output logic                oRAM_WREN,
    input  logic [DW-1:0]       iRAM_Q,
    output logic                oERR
);

    import ram_arb_pkg::*;

    localparam int unsigned IW = idxWidth(N_REQ);
    localparam int unsigned CW = cntWidth(LOCK_MAX);

    logic [IW-1:0]    lastGnt;
    logic             gntValid;   // lastGnt refers to a real grant since reset
    logic [CW-1:0]    lockCnt;
    logic [N_REQ-1:0] rdTag;
    logic             rdOob;
    logic             errFlag;
    logic [AW-1:0]    addrHold;
    logic [DW-1:0]    dataHold;

    logic [N_REQ-1:0] pickGnt;
    logic [N_REQ-1:0] gnt;
    logic             gntAny;
    logic [IW-1:0]    gntIdx;
    logic [AW-1:0]    selAddr;
    logic [DW-1:0]    selData;
    logic             selWe;
    logic             inRange;
    logic             lockHold;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) uPick (
        .req     (iREQ),
        .lastGnt (lastGnt),
        .gnt     (pickGnt)
    );

    // Owner keeps the port while it locks, still requests and has row budget left
    always_comb begin
        lockHold = gntValid && iREQ[lastGnt] && iLOCK[lastGnt] &&
                   (lockCnt < CW'(LOCK_MAX));
    end

    // Final grant, suppressed entirely while reset is asserted
    always_comb begin
        gnt = '0;
        if (iRST_N) begin
            gnt = lockHold ? (N_REQ'(1) << lastGnt) : pickGnt;
        end
    end

    // Mux the granted requester's fields onto the RAM port; idle keeps last values
    always_comb begin
        gntAny  = |gnt;
        gntIdx  = '0;
        selAddr = addrHold;
        selData = dataHold;
        selWe   = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                gntIdx  = IW'(k);
                selAddr = iADDR[k*AW +: AW];
                selData = iWDATA[k*DW +: DW];
                selWe   = iWE[k];
            end
        end
        inRange = (32'(selAddr) < DEPTH);
    end

    assign oGNT      = gnt;
    assign oRAM_ADDR = selAddr;
    assign oRAM_DATA = selData;
    assign oRAM_WREN = gntAny && selWe && inRange;
    assign oRVAL     = rdTag;
    assign oRDATA    = ((|rdTag) && !rdOob) ? iRAM_Q : '0;
    assign oERR      = errFlag;

    // Arbitration history, lock counter, read tag pipeline and error flag
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            lastGnt  <= IW'(N_REQ - 1);
            gntValid <= 1'b0;
            lockCnt  <= '0;
            rdTag    <= '0;
            rdOob    <= 1'b0;
            errFlag  <= 1'b0;
            addrHold <= '0;
            dataHold <= '0;
        end else begin
            rdTag <= gnt & ~iWE;
            rdOob <= gntAny && !inRange;
            if (gntAny && !inRange) begin
                errFlag <= 1'b1;
            end
            if (gntAny) begin
                lastGnt  <= gntIdx;
                gntValid <= 1'b1;
                addrHold <= selAddr;
                dataHold <= selData;
                // A new owner starts its count at this transfer; the budget saturates
                if (!iLOCK[gntIdx]) begin
                    lockCnt <= '0;
                end else if (!gntValid || (gntIdx != lastGnt)) begin
                    lockCnt <= CW'(1);
                end else if (lockCnt < CW'(LOCK_MAX)) begin
                    lockCnt <= lockCnt + CW'(1);
                end
            end else if (!iLOCK[lastGnt]) begin
                lockCnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arb.sv
// Directed bench for ram_port_arb with a one-cycle-latency RAM model.
module tb_ram_port_arb;

    import ram_arb_pkg::*;

    localparam int unsigned MEMW = 1 << AW;
    localparam int unsigned NVEC = 14;

    localparam logic [AW-1:0] A0   = AW'(0);
    localparam logic [AW-1:0] A5   = AW'(5);
    localparam logic [AW-1:0] A7   = AW'(7);
    localparam logic [AW-1:0] A10  = AW'(10);
    localparam logic [AW-1:0] A20  = AW'(20);
    localparam logic [AW-1:0] A30  = AW'(30);
    localparam logic [AW-1:0] AOOB = AW'(120000);
    localparam logic [DW-1:0] WD1  = 24'h111111;
    localparam logic [DW-1:0] WD2  = 24'h222222;

    logic                       clk = 1'b0;
    logic                       rstN;
    logic [N_REQ-1:0]           req;
    logic [N_REQ-1:0]           lock;
    logic [N_REQ-1:0]           we;
    logic [N_REQ-1:0][AW-1:0]   addr;
    logic [N_REQ-1:0][DW-1:0]   wdata;
    logic [N_REQ-1:0]           gnt;
    logic [N_REQ-1:0]           rval;
    logic [DW-1:0]              rdata;
    logic [AW-1:0]              ramAddr;
    logic [DW-1:0]              ramData;
    logic                       ramWren;
    logic [DW-1:0]              ramQ;
    logic                       err;

    int nVec = 0;
    int nMis = 0;

    typedef struct {
        logic [N_REQ-1:0]         req;
        logic [N_REQ-1:0]         we;
        logic [N_REQ-1:0][AW-1:0] addr;
        logic [DW-1:0]            d0;
        logic [N_REQ-1:0]         eGnt;
        logic                     eWren;
        logic [AW-1:0]            eAddr;
        logic [DW-1:0]            eData;
        logic [N_REQ-1:0]         eRval;
        logic [DW-1:0]            eRdata;
    } vec_t;

    vec_t tbl [NVEC];

    ram_port_arb #(
        .N_REQ    (N_REQ),
        .AW       (AW),
        .DW       (DW),
        .DEPTH    (DEPTH),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .iCLK      (clk),
        .iRST_N    (rstN),
        .iREQ      (req),
        .iLOCK     (lock),
        .iWE       (we),
        .iADDR     (addr),
        .iWDATA    (wdata),
        .oGNT      (gnt),
        .oRVAL     (rval),
        .oRDATA    (rdata),
        .oRAM_ADDR (ramAddr),
        .oRAM_DATA (ramData),
        .oRAM_WREN (ramWren),
        .iRAM_Q    (ramQ),
        .oERR      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] seed(input int unsigned a);
        return DW'(32'h100000 + a);
    endfunction

    // RAM model: seeded with a known pattern on the first edge, registered read
    logic [DW-1:0] mem [MEMW];
    bit            seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int unsigned i = 0; i < MEMW; i++) mem[i] <= seed(i);
            seeded <= 1'b1;
        end else if (ramWren) begin
            mem[ramAddr] <= ramData;
        end
        ramQ <= seeded ? mem[ramAddr] : '0;
    end

    function automatic vec_t mk(
        input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] w,
        input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
        input logic [DW-1:0] d0, input logic [N_REQ-1:0] g, input logic wr,
        input logic [AW-1:0] ea, input logic [DW-1:0] ed,
        input logic [N_REQ-1:0] rv, input logic [DW-1:0] rd);
        vec_t v;
        v.req = r; v.we = w; v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
        v.d0 = d0; v.eGnt = g; v.eWren = wr; v.eAddr = ea; v.eData = ed;
        v.eRval = rv; v.eRdata = rd;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        req = '0; lock = '0; we = '0;
        addr[0] = A0; addr[1] = A0; addr[2] = A0;
        wdata[0] = '0; wdata[1] = WD1; wdata[2] = WD2;
    endtask

    task automatic applyReset();
        rstN = 1'b0;
        idleInputs();
        nextCycle();
        nextCycle();
        rstN = 1'b1;
    endtask

    task automatic checkAllZero(input string tag);
        cmp({tag, " gnt"},   32'(gnt),     32'(0));
        cmp({tag, " rval"},  32'(rval),    32'(0));
        cmp({tag, " rdata"}, 32'(rdata),   32'(0));
        cmp({tag, " wren"},  32'(ramWren), 32'(0));
        cmp({tag, " addr"},  32'(ramAddr), 32'(0));
        cmp({tag, " data"},  32'(ramData), 32'(0));
        cmp({tag, " err"},   32'(err),     32'(0));
    endtask

    initial begin
        int  n1;
        bit  other;

        //            req     we      a0   a1   a2   d0          gnt    wr  eAddr eData       rval   rdata
        tbl[0]  = mk(3'b111, 3'b001, A5,  A10, A20, 24'hABCDEF, 3'b001, 1, A5,  24'hABCDEF, 3'b000, 24'h0);
        tbl[1]  = mk(3'b111, 3'b001, A5,  A10, A20, 24'hABCDEF, 3'b010, 0, A10, WD1,        3'b000, 24'h0);
        tbl[2]  = mk(3'b111, 3'b001, A5,  A10, A20, 24'hABCDEF, 3'b100, 0, A20, WD2,        3'b010, 24'h10000A);
        tbl[3]  = mk(3'b111, 3'b001, A5,  A10, A20, 24'hABCDEF, 3'b001, 1, A5,  24'hABCDEF, 3'b100, 24'h100014);
        tbl[4]  = mk(3'b100, 3'b000, A5,  A10, A5,  24'hABCDEF, 3'b100, 0, A5,  WD2,        3'b000, 24'h0);
        tbl[5]  = mk(3'b000, 3'b000, A5,  A10, A5,  24'hABCDEF, 3'b000, 0, A5,  WD2,        3'b100, 24'hABCDEF);
        tbl[6]  = mk(3'b110, 3'b000, A0,  A10, A20, 24'h000000, 3'b010, 0, A10, WD1,        3'b000, 24'h0);
        tbl[7]  = mk(3'b110, 3'b000, A0,  A10, A20, 24'h000000, 3'b100, 0, A20, WD2,        3'b010, 24'h10000A);
        tbl[8]  = mk(3'b110, 3'b000, A0,  A10, A20, 24'h000000, 3'b010, 0, A10, WD1,        3'b100, 24'h100014);
        tbl[9]  = mk(3'b110, 3'b000, A0,  A10, A20, 24'h000000, 3'b100, 0, A20, WD2,        3'b010, 24'h10000A);
        tbl[10] = mk(3'b000, 3'b000, A0,  A10, A20, 24'h000000, 3'b000, 0, A20, WD2,        3'b100, 24'h100014);
        tbl[11] = mk(3'b011, 3'b001, A7,  A7,  A20, 24'h123456, 3'b001, 1, A7,  24'h123456, 3'b000, 24'h0);
        tbl[12] = mk(3'b010, 3'b001, A7,  A7,  A20, 24'h123456, 3'b010, 0, A7,  WD1,        3'b000, 24'h0);
        tbl[13] = mk(3'b000, 3'b001, A7,  A7,  A20, 24'h123456, 3'b000, 0, A7,  WD1,        3'b010, 24'h123456);

        // Reset held with everything requesting: all outputs must be zero
        rstN = 1'b0;
        idleInputs();
        req = 3'b111; we = 3'b111;
        addr[0] = A5; addr[1] = A10; addr[2] = A20; wdata[0] = 24'hABCDEF;
        nextCycle();
        @(negedge clk);
        checkAllZero("reset");
        nextCycle();
        rstN = 1'b1;

        // Table: round-robin order, write/read, alternating reads, write vs read
        for (int i = 0; i < NVEC; i++) begin
            req = tbl[i].req; we = tbl[i].we; lock = '0;
            addr = tbl[i].addr;
            wdata[0] = tbl[i].d0; wdata[1] = WD1; wdata[2] = WD2;
            @(negedge clk);
            cmp($sformatf("v%0d gnt", i),   32'(gnt),     32'(tbl[i].eGnt));
            cmp($sformatf("v%0d wren", i),  32'(ramWren), 32'(tbl[i].eWren));
            cmp($sformatf("v%0d addr", i),  32'(ramAddr), 32'(tbl[i].eAddr));
            cmp($sformatf("v%0d data", i),  32'(ramData), 32'(tbl[i].eData));
            cmp($sformatf("v%0d rval", i),  32'(rval),    32'(tbl[i].eRval));
            cmp($sformatf("v%0d rdata", i), 32'(rdata),   32'(tbl[i].eRdata));
            cmp($sformatf("v%0d err", i),   32'(err),     32'(0));
            nextCycle();
        end

        // Row lock: requester 1 keeps 400 grants while requester 0 waits
        applyReset();
        req = 3'b011; lock = 3'b010; we = '0; addr[1] = A30;
        @(negedge clk);
        cmp("lock first gnt", 32'(gnt), 32'(1 << REQ_PIXEL));
        nextCycle();
        n1 = 0;
        other = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (gnt != 3'(1 << REQ_FILTER)) begin
                other = 1'b1;
                break;
            end
            n1++;
            nextCycle();
        end
        cmp("lock hold count", 32'(n1), 32'(LOCK_MAX));
        cmp("lock released", 32'(other), 32'(1));
        cmp("lock gnt 401", 32'(gnt), 32'(1 << REQ_PIXEL));
        nextCycle();

        // Out-of-range write from requester 1
        idleInputs();
        req = 3'b010; we = 3'b010; addr[1] = AOOB;
        @(negedge clk);
        cmp("oob wr gnt",  32'(gnt),     32'(1 << REQ_FILTER));
        cmp("oob wr wren", 32'(ramWren), 32'(0));
        cmp("oob err pre", 32'(err),     32'(0));
        nextCycle();
        idleInputs();
        @(negedge clk);
        cmp("oob err set", 32'(err), 32'(1));
        nextCycle();

        // Out-of-range read from requester 2 returns zero data
        req = 3'b100; addr[2] = AOOB;
        @(negedge clk);
        cmp("oob rd gnt", 32'(gnt), 32'(1 << REQ_OUTPUT));
        nextCycle();
        idleInputs();
        @(negedge clk);
        cmp("oob rd rval",  32'(rval),  32'(1 << REQ_OUTPUT));
        cmp("oob rd rdata", 32'(rdata), 32'(0));
        for (int c = 0; c < 5; c++) nextCycle();
        @(negedge clk);
        cmp("oob err sticky", 32'(err), 32'(1));
        nextCycle();

        // Reset clears the error flag
        applyReset();
        @(negedge clk);
        cmp("err after reset", 32'(err), 32'(0));
        nextCycle();

        // Reset dropped right after a read grant: the read is lost
        req = 3'b010; we = '0; addr[1] = A10;
        @(negedge clk);
        cmp("midrst gnt", 32'(gnt), 32'(1 << REQ_FILTER));
        nextCycle();
        rstN = 1'b0;
        @(negedge clk);
        checkAllZero("midrst");
        nextCycle();
        rstN = 1'b1;
        idleInputs();
        @(negedge clk);
        cmp("midrst rval a", 32'(rval), 32'(0));
        nextCycle();
        @(negedge clk);
        cmp("midrst rval b", 32'(rval), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
